// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: multi-line CP0 interrupt controller with masking, fixed priority, STATUS/CAUSE/EPC and ERET redirect
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [15:0] EDGE_MASK    = 16'hFFFF,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cp0_wen,
  input  logic [4:0]         cp0_waddr,
  input  logic [31:0]        cp0_wdata,
  input  logic [4:0]         cp0_raddr,
  output logic [31:0]        cp0_rdata,
  output logic               irq_req,
  input  logic               irq_ack,
  input  logic [31:0]        epc_in,
  input  logic               eret,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic               in_service
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_nx;
  logic [NUM_IRQ-1:0] s1, s2, s3, ip_edge, ip, im, p, edge_m, clr;
  logic [31:0] epc, status, cause;
  logic [4:0] irq_id, winner;
  logic ie, ack_ok, eret_ok, wr_status, wr_cause, wr_epc;
  logic unused;
  assign unused = ^cp0_wdata;
  assign edge_m = EDGE_MASK[NUM_IRQ-1:0];
  assign wr_status = cp0_wen && cp0_waddr == 5'd12;
  assign wr_cause = cp0_wen && cp0_waddr == 5'd13;
  assign wr_epc = cp0_wen && cp0_waddr == 5'd14;
  assign clr = wr_cause ? cp0_wdata[8 +: NUM_IRQ] : '0;
  // level lines bypass the latch and follow the synchroniser directly
  assign ip = (ip_edge & edge_m) | (s2 & ~edge_m);
  assign p = ip & im;
  assign ack_ok = state == REQ && irq_ack;
  assign eret_ok = state == SERVICE && eret;
  assign irq_req = state == REQ;
  assign in_service = state == SERVICE;
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (p[i]) winner = 5'(i);
  end
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (ie && |p) ? REQ : IDLE;
      REQ:     state_nx = irq_ack ? SERVICE : (!ie || ~|p) ? IDLE : REQ;
      SERVICE: state_nx = eret ? IDLE : SERVICE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    status = '0;
    status[0] = ie;
    status[8 +: NUM_IRQ] = im;
    cause = '0;
    cause[8 +: NUM_IRQ] = ip;
    cause[31:27] = irq_id;
    cp0_rdata = cp0_raddr == 5'd12 ? status :
                cp0_raddr == 5'd13 ? cause :
                cp0_raddr == 5'd14 ? epc : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      ip_edge <= '0;
      im <= '0;
      ie <= 1'b0;
      epc <= '0;
      irq_id <= '0;
      state <= IDLE;
      jump_en <= 1'b0;
      jump_addr <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
      ip_edge <= ((ip_edge & ~clr) | (s2 & ~s3)) & edge_m;
      im <= wr_status ? cp0_wdata[8 +: NUM_IRQ] : im;
      ie <= ack_ok ? 1'b0 : eret_ok ? 1'b1 : wr_status ? cp0_wdata[0] : ie;
      epc <= ack_ok ? epc_in : wr_epc ? cp0_wdata : epc;
      irq_id <= ack_ok ? winner : irq_id;
      state <= state_nx;
      jump_en <= ack_ok | eret_ok;
      jump_addr <= ack_ok ? HANDLER_ADDR : eret_ok ? epc : jump_addr;
    end
  end
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb_cp0_irq_ctrl: directed self-checking bench for cp0_irq_ctrl (line 3 level, others edge)
module tb_cp0_irq_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] irq_in = '0;
  logic cp0_wen = 0;
  logic [4:0] cp0_waddr = '0, cp0_raddr = '0;
  logic [31:0] cp0_wdata = '0, cp0_rdata, epc_in = '0, jump_addr;
  logic irq_req, irq_ack = 0, eret = 0, jump_en, in_service;
  int checks = 0, failures = 0;

  cp0_irq_ctrl #(.NUM_IRQ(8), .EDGE_MASK(16'hFFF7), .HANDLER_ADDR(32'h0000_0004)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cp0_wen(cp0_wen), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .irq_req(irq_req),
    .irq_ack(irq_ack), .epc_in(epc_in), .eret(eret), .jump_en(jump_en), .jump_addr(jump_addr),
    .in_service(in_service));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_wen = 1; cp0_waddr = a; cp0_wdata = d;
    tick;
    cp0_wen = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (irq_req !== 1'b1 && n < 20) begin tick; n++; end
    ok = irq_req === 1'b1;
  endtask

  task automatic ack(input logic [31:0] pc);
    irq_ack = 1; epc_in = pc;
    tick;
    irq_ack = 0;
  endtask

  task automatic do_eret;
    eret = 1;
    tick;
    eret = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1;
    repeat (2) tick;
    rst = 0;
    checks++; if ({irq_req, jump_en, in_service} !== 3'b000) begin failures++; $display("FAIL reset_outs got=%b exp=000", {irq_req, jump_en, in_service}); end
    checks++; if (jump_addr !== 32'h0) begin failures++; $display("FAIL reset_jump_addr got=%h exp=0", jump_addr); end
    rd(5'd12, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
    rd(5'd13, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", d); end
    rd(5'd14, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", d); end
    rd(5'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_other got=%h exp=0", d); end
  endtask

  task automatic test_entry;
    logic [31:0] d;
    wr(5'd12, 32'h0000_0401);
    irq_in[2] = 1;
    tick;
    irq_in[2] = 0;
    tick; tick;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", irq_req); end
    tick;
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL latency_4 got=%b exp=1", irq_req); end
    ack(32'h0000_0100);
    checks++; if ({jump_en, in_service, irq_req} !== 3'b110) begin failures++; $display("FAIL entry_flags got=%b exp=110", {jump_en, in_service, irq_req}); end
    checks++; if (jump_addr !== 32'h4) begin failures++; $display("FAIL entry_addr got=%h exp=00000004", jump_addr); end
    rd(5'd14, d);
    checks++; if (d !== 32'h100) begin failures++; $display("FAIL entry_epc got=%h exp=00000100", d); end
    rd(5'd13, d);
    checks++; if (d[31:27] !== 5'd2) begin failures++; $display("FAIL entry_id got=%0d exp=2", d[31:27]); end
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_0400) begin failures++; $display("FAIL entry_status got=%h exp=00000400", d); end
    tick;
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL entry_pulse got=%b exp=0", jump_en); end
  endtask

  task automatic test_eret;
    logic [31:0] d;
    wr(5'd13, 32'h0000_0400);
    rd(5'd13, d);
    checks++; if (d[15:8] !== 8'h00) begin failures++; $display("FAIL w1c_ip got=%h exp=00", d[15:8]); end
    do_eret;
    checks++; if ({jump_en, in_service} !== 2'b10) begin failures++; $display("FAIL eret_flags got=%b exp=10", {jump_en, in_service}); end
    checks++; if (jump_addr !== 32'h100) begin failures++; $display("FAIL eret_addr got=%h exp=00000100", jump_addr); end
    rd(5'd12, d);
    checks++; if (d[0] !== 1'b1) begin failures++; $display("FAIL eret_ie got=%b exp=1", d[0]); end
    tick;
    checks++; if ({irq_req, jump_en} !== 2'b00) begin failures++; $display("FAIL eret_quiet got=%b exp=00", {irq_req, jump_en}); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    bit ok;
    wr(5'd12, 32'h0000_FF01);
    irq_in = 8'h22;
    tick;
    irq_in = '0;
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_req1 got=0 exp=1"); end
    ack(32'h0000_0300);
    rd(5'd13, d);
    checks++; if (d[31:27] !== 5'd1) begin failures++; $display("FAIL b2b_id1 got=%0d exp=1", d[31:27]); end
    checks++; if (d[15:8] !== 8'h22) begin failures++; $display("FAIL b2b_ip got=%h exp=22", d[15:8]); end
    wr(5'd13, 32'h0000_0200);
    do_eret;
    checks++; if (jump_addr !== 32'h300) begin failures++; $display("FAIL b2b_eret_addr got=%h exp=00000300", jump_addr); end
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_req2 got=0 exp=1"); end
    ack(32'h0000_0400);
    rd(5'd13, d);
    checks++; if (d[31:27] !== 5'd5) begin failures++; $display("FAIL b2b_id2 got=%0d exp=5", d[31:27]); end
    wr(5'd13, 32'h0000_2000);
    do_eret;
    tick;
  endtask

  task automatic test_level_drop;
    logic [31:0] d;
    bit ok, saw_jump;
    wr(5'd12, 32'h0000_0801);
    irq_in[3] = 1;
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL level_req got=0 exp=1"); end
    irq_in[3] = 0;
    saw_jump = 0;
    repeat (3) begin tick; saw_jump |= jump_en; end
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL level_drop got=%b exp=0", irq_req); end
    checks++; if (saw_jump || in_service) begin failures++; $display("FAIL level_nojump got=%b exp=00", {saw_jump, in_service}); end
    rd(5'd13, d);
    checks++; if (d[11] !== 1'b0) begin failures++; $display("FAIL level_ip got=%b exp=0", d[11]); end
    ack(32'h0000_0900);
    checks++; if ({jump_en, in_service} !== 2'b00) begin failures++; $display("FAIL idle_ack got=%b exp=00", {jump_en, in_service}); end
  endtask

  task automatic test_ack_mtc0;
    logic [31:0] d;
    bit ok;
    irq_in[3] = 1;
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL mtc0_req got=0 exp=1"); end
    irq_ack = 1; epc_in = 32'h0000_0500;
    cp0_wen = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_FF01;
    tick;
    irq_ack = 0; cp0_wen = 0;
    checks++; if (jump_en !== 1'b1) begin failures++; $display("FAIL mtc0_jump got=%b exp=1", jump_en); end
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_FF00) begin failures++; $display("FAIL mtc0_status got=%h exp=0000ff00", d); end
    irq_in[3] = 0;
    repeat (3) tick;
    do_eret;
    checks++; if (jump_en !== 1'b1 || jump_addr !== 32'h500) begin failures++; $display("FAIL mtc0_eret got=%b/%h exp=1/00000500", jump_en, jump_addr); end
    do_eret;
    checks++; if (jump_en !== 1'b0 || irq_req !== 1'b0) begin failures++; $display("FAIL idle_eret got=%b exp=00", {jump_en, irq_req}); end
  endtask

  task automatic test_reset_in_service;
    logic [31:0] d;
    bit ok;
    irq_in[0] = 1;
    tick;
    irq_in[0] = 0;
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rsvc_req got=0 exp=1"); end
    ack(32'h0000_0600);
    checks++; if (in_service !== 1'b1) begin failures++; $display("FAIL rsvc_service got=%b exp=1", in_service); end
    rst = 1;
    tick;
    rst = 0;
    checks++; if ({irq_req, jump_en, in_service} !== 3'b000 || jump_addr !== 32'h0) begin failures++; $display("FAIL rsvc_outs got=%b/%h exp=000/0", {irq_req, jump_en, in_service}, jump_addr); end
    rd(5'd14, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rsvc_epc got=%h exp=0", d); end
    rd(5'd12, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rsvc_status got=%h exp=0", d); end
    do_eret;
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL rsvc_eret got=%b exp=0", jump_en); end
  endtask

  initial begin
    test_reset;
    test_entry;
    test_eret;
    test_back_to_back;
    test_level_drop;
    test_ack_mtc0;
    test_reset_in_service;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
Parametrised coprocessor-0 interrupt controller for the 5-stage MIPS core, replacing the single-line interrupt input with NUM_IRQ lines. Each line is configurable as edge or level. The block provides masking, fixed priority, STATUS/CAUSE/EPC registers accessible by mfc0/mtc0, and a request/acknowledge handshake with the pipeline. It generates the redirect PC on interrupt entry and on ERET.

Parameters:
NUM_IRQ, 8, number of external interrupt lines; legal range 1..16.
EDGE_MASK, 16'hFFFF, per-line mode; bit i=1 means rising-edge latched, bit i=0 means level; only bits [NUM_IRQ-1:0] are used.
HANDLER_ADDR, 32'h0000_0004, PC of the interrupt handler entry.

Ports:
clk  in  1  main clock, all state on the rising edge
rst  in  1  synchronous reset, active-high
irq_in  in  NUM_IRQ  asynchronous external interrupt lines
cp0_wen  in  1  mtc0 write strobe
cp0_waddr  in  5  mtc0 register number
cp0_wdata  in  32  mtc0 data
cp0_raddr  in  5  mfc0 register number
cp0_rdata  out  32  mfc0 data, combinational from cp0_raddr
irq_req  out  1  interrupt request to the pipeline, registered
irq_ack  in  1  pipeline accepts the request this cycle
epc_in  in  32  resume PC, sampled on irq_ack
eret  in  1  ERET in the commit stage
jump_en  out  1  one-cycle redirect pulse, registered
jump_addr  out  32  redirect target, valid when jump_en=1
in_service  out  1  high between acceptance and ERET

Behaviour:
- Reset: irq_req=0, jump_en=0, jump_addr=0, in_service=0, cp0_rdata=0 when cp0_raddr selects nothing. All registers are 0 (IE=0, IM=0, IP=0, EPC=0) and synchronisers are cleared. Reset mid-service returns to IDLE with no jump.
- Synchroniser: 2 flops per line (s1, s2), plus s3 for edge detect. irq_in rising before edge N gives s2=1 after edge N+1.
- Edge lines: IP[i] sets on s2&~s3 and stays set until software writes 1 to CAUSE bit 8+i (W1C). If a set and a W1C hit the same line in the same cycle, set wins.
- Level lines: IP[i]=s2[i]; writes to that bit are ignored.
- Pending vector P = IP & IM. Winner = lowest index i with P[i]=1 (line 0 has the highest priority).
- Registers, where unlisted bits read 0 and ignore writes:
  - STATUS (reg 12): [0]=IE; [8+NUM_IRQ-1:8]=IM.
  - CAUSE (reg 13): [6:2]=0 (ExcCode Int); [8+NUM_IRQ-1:8]=IP; [31:27]=irq_id latched on ack.
  - EPC (reg 14): read/write.
  - Reads of other register numbers return 0. A read and a write to the same register in the same cycle returns the old value.
- FSM:
  - IDLE: when IE & |P, go to REQ and set irq_req=1 on the next edge.
  - REQ: irq_req=1.
    - irq_ack: EPC<=epc_in, IE<=0, irq_id<=winner, in_service<=1, jump_en<=1, jump_addr<=HANDLER_ADDR, then go to SERVICE.
    - Otherwise, if IE=0 or P=0 (software mask or level drop): return to IDLE and clear irq_req on the next edge.
    - irq_ack wins over a same-cycle drop.
  - SERVICE: irq_req=0.
    - eret: IE<=1, in_service<=0, jump_en<=1, jump_addr<=EPC (the value before any same-cycle mtc0), then go to IDLE.
  - irq_ack outside REQ and eret outside SERVICE are ignored.
- Same-cycle mtc0 STATUS with ack or eret: the hardware update of IE wins, IM takes the written value. Same-cycle mtc0 EPC with ack: the ack value wins.
- jump_en is high for exactly one cycle per accepted ack or valid eret.
- Minimum latency from an irq_in edge (IE=1, IM set) to irq_req=1 is 4 clock edges.

Test Plan:
1. Reset, then IM=8'h04, IE=1, pulse irq_in[2] for 1 cycle -> irq_req=1 four edges later. Ack with epc_in=32'h0000_0100 -> next cycle jump_en=1, jump_addr=32'h4; EPC reads 32'h100; CAUSE[31:27]=2; STATUS[0]=0; in_service=1.
2. From SERVICE, write CAUSE=32'h0000_0400 (W1C bit 2), then eret -> jump_en=1, jump_addr=32'h100, IE=1, irq_req stays 0, in_service=0.
3. IM=8'hFF, raise lines 5 and 1 in the same cycle, ack -> irq_id=1. After eret, irq_req reasserts without new stimulus, ack gives irq_id=5.
4. EDGE_MASK bit 3=0 (level), irq_in[3] high, IE=1, IM[3]=1 -> irq_req=1. Drop irq_in[3] before ack -> irq_req falls within 3 cycles and FSM returns to IDLE with no jump_en.
5. In REQ, apply irq_ack and mtc0 STATUS=32'h0000_FF01 in the same cycle -> IE reads 0, IM=8'hFF, jump_en=1. eret while in IDLE -> no jump_en.
6. Assert rst in SERVICE -> next cycle all outputs 0, EPC=0, and a later eret produces no jump_en.
